// File: rtl/coin_acceptor_pkg.sv
// -----------------------------------------------------------------------------
// coin_acceptor_pkg
//   Shared definitions for the coin acceptor front end and the vending FSM.
//   - Measure-FSM state encodings as fixed-width constants. The encodings are
//     kept stable so existing consumers of the state code stay compatible.
//   - Coin value encoding carried on coin_val.
//   - width_in_range(): inclusive window test used to classify coin widths.
// Ports: none (package).
// -----------------------------------------------------------------------------
package coin_acceptor_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_WAIT_LOW = 3'd0;
  localparam state_t ST_IDLE     = 3'd1;
  localparam state_t ST_MEASURE  = 3'd2;
  localparam state_t ST_EMIT     = 3'd3;
  localparam state_t ST_JAM      = 3'd4;

  localparam logic COIN_5C  = 1'b0;
  localparam logic COIN_10C = 1'b1;

  // Inclusive window test: lo <= width <= hi.
  function automatic logic width_in_range(input int unsigned width,
                                          input int unsigned lo,
                                          input int unsigned hi);
    return (width >= lo) && (width <= hi);
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// -----------------------------------------------------------------------------
// coin_acceptor_if
//   Bundles the coin-path signals between the sensor/machine side and the coin
//   acceptor.
//   master : drives coin_sense / accept_en, observes strobes and status.
//   slave  : the acceptor; samples coin_sense / accept_en, drives the rest.
//   Signals:
//     coin_sense   raw sensor level, 1 = beam occluded (asynchronous to clk)
//     accept_en    machine can take coins (sampled at coin leading edge)
//     coin_in_en   one-cycle strobe, valid coin accepted
//     coin_val     0 = 5c, 1 = 10c, only meaningful with coin_in_en
//     coin_reject  one-cycle strobe, coin sent to return chute
//     jam          level, coin stuck in the sensor
//     busy         level, a coin is being handled
//     tally_*      16-bit saturating counters (COIN_ACCEPTOR_TALLY_EN only)
// Optional feature macro: COIN_ACCEPTOR_TALLY_EN.
// -----------------------------------------------------------------------------
interface coin_acceptor_if;

  logic coin_sense;
  logic accept_en;
  logic coin_in_en;
  logic coin_val;
  logic coin_reject;
  logic jam;
  logic busy;

`ifdef COIN_ACCEPTOR_TALLY_EN
  logic [15:0] tally_5c;
  logic [15:0] tally_10c;
  logic [15:0] tally_rej;

  modport master (
    output coin_sense, accept_en,
    input  coin_in_en, coin_val, coin_reject, jam, busy,
    input  tally_5c, tally_10c, tally_rej
  );

  modport slave (
    input  coin_sense, accept_en,
    output coin_in_en, coin_val, coin_reject, jam, busy,
    output tally_5c, tally_10c, tally_rej
  );
`else
  modport master (
    output coin_sense, accept_en,
    input  coin_in_en, coin_val, coin_reject, jam, busy
  );

  modport slave (
    input  coin_sense, accept_en,
    output coin_in_en, coin_val, coin_reject, jam, busy
  );
`endif

endinterface

// File: rtl/coin_acceptor_debounce.sv
// -----------------------------------------------------------------------------
// coin_debounce
//   Synchronizes the raw optical sensor level into clk and filters it: the
//   clean level follows the synced level only after the synced level has
//   differed from it for DEBOUNCE_CYC consecutive cycles. Rising and falling
//   edges get the same delay, so pulse width is preserved.
//   Ports:
//     clk        in  clock
//     reset      in  asynchronous, active-high reset
//     sense_raw  in  raw sensor level, asynchronous to clk
//     sense_db   out debounced level (registered)
//     settled    out synchronizer primed and synced level equals sense_db
// -----------------------------------------------------------------------------
module coin_debounce #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sense_raw,
  output logic sense_db,
  output logic settled
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  // vld_q fills with ones after reset; until it is full the synchronizer
  // output still reflects reset values rather than the sensor.
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   synced_s;

  assign synced_s = sync_q[SYNC_STAGES-1];

  // Next-state for synchronizer chain and stability filter.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sense_raw};
    vld_d  = {vld_q[SYNC_STAGES-2:0], 1'b1};
    cnt_d  = cnt_q;
    db_d   = db_q;
    if (synced_s == db_q) begin
      cnt_d = {DB_W{1'b0}};
    end else if (cnt_q == DB_LAST) begin
      cnt_d = {DB_W{1'b0}};
      db_d  = synced_s;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  // Synchronizer, stability counter and clean-level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      vld_q  <= {SYNC_STAGES{1'b0}};
      cnt_q  <= {DB_W{1'b0}};
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign sense_db = db_q;
  assign settled  = vld_q[SYNC_STAGES-1] && (synced_s == db_q);

endmodule

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
//   Coin path front end: debounces the optical sensor, measures how long a coin
//   occludes the beam, classifies it as 5c (short) or 10c (long), rejects
//   out-of-window or locked-out coins and flags jams.
//   Ports:
//     clk    in  clock
//     reset  in  asynchronous, active-high reset
//     bus    coin_acceptor_if.slave
//            in : coin_sense, accept_en
//            out: coin_in_en, coin_val, coin_reject, jam, busy (all registered)
//            out: tally_5c, tally_10c, tally_rej (COIN_ACCEPTOR_TALLY_EN only)
//   Optional feature macro: COIN_ACCEPTOR_TALLY_EN adds saturating 16-bit
//   tallies of accepted 5c, accepted 10c and rejected/jammed coins.
// -----------------------------------------------------------------------------
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned MIN5_CYC     = 100,
  parameter int unsigned MAX5_CYC     = 400,
  parameter int unsigned MIN10_CYC    = 600,
  parameter int unsigned MAX10_CYC    = 1200,
  parameter int unsigned JAM_CYC      = 4000,
  parameter int unsigned CNT_W        = 13
) (
  input  logic            clk,
  input  logic            reset,
  coin_acceptor_if.slave  bus
);

  localparam logic [CNT_W-1:0] JAM_C = CNT_W'(JAM_CYC);

  logic sense_db_s;
  logic settled_s;

  coin_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .sense_raw (bus.coin_sense),
    .sense_db  (sense_db_s),
    .settled   (settled_s)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             lock_q, lock_d;
  logic             in_en_q, in_en_d;
  logic             val_q, val_d;
  logic             rej_q, rej_d;
  logic             jam_q, jam_d;
  logic             busy_q, busy_d;
  logic             jam_enter_s;

  // Saturating increment: the width counter never wraps.
  assign cnt_inc_s = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : (cnt_q + CNT_W'(1));

  // Measure FSM, width counter and classification. Strobes are computed on
  // the falling-edge cycle so they appear registered during EMIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_d      = lock_q;
    in_en_d     = 1'b0;
    val_d       = 1'b0;
    rej_d       = 1'b0;
    jam_d       = jam_q;
    jam_enter_s = 1'b0;
    case (state_q)
      ST_WAIT_LOW: begin
        // settled keeps a coin sitting in the beam at reset release from
        // being mistaken for an empty sensor while the synchronizer fills.
        if (!sense_db_s && settled_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      ST_IDLE: begin
        if (sense_db_s) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_W'(1);
          lock_d  = ~bus.accept_en;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (sense_db_s) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s >= JAM_C) begin
            state_d     = ST_JAM;
            jam_d       = 1'b1;
            jam_enter_s = 1'b1;
          end else begin
            state_d = ST_MEASURE;
          end
        end else begin
          state_d = ST_EMIT;
          if (!lock_q && width_in_range(32'(cnt_q), MIN5_CYC, MAX5_CYC)) begin
            in_en_d = 1'b1;
            val_d   = COIN_5C;
          end else if (!lock_q && width_in_range(32'(cnt_q), MIN10_CYC, MAX10_CYC)) begin
            in_en_d = 1'b1;
            val_d   = COIN_10C;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        state_d = ST_IDLE;
      end
      ST_JAM: begin
        if (!sense_db_s) begin
          state_d = ST_WAIT_LOW;
          jam_d   = 1'b0;
        end else begin
          state_d = ST_JAM;
        end
      end
      default: begin
        state_d = ST_WAIT_LOW;
        jam_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT_LOW;
      cnt_q   <= {CNT_W{1'b0}};
      lock_q  <= 1'b0;
      in_en_q <= 1'b0;
      val_q   <= 1'b0;
      rej_q   <= 1'b0;
      jam_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      in_en_q <= in_en_d;
      val_q   <= val_d;
      rej_q   <= rej_d;
      jam_q   <= jam_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.coin_in_en  = in_en_q;
  assign bus.coin_val    = val_q;
  assign bus.coin_reject = rej_q;
  assign bus.jam         = jam_q;
  assign bus.busy        = busy_q;

`ifdef COIN_ACCEPTOR_TALLY_EN
  logic [15:0] t5_q, t5_d;
  logic [15:0] t10_q, t10_d;
  logic [15:0] trej_q, trej_d;

  // Tallies advance alongside the strobe they count; jams count as rejects.
  always_comb begin
    t5_d   = t5_q;
    t10_d  = t10_q;
    trej_d = trej_q;
    if (in_en_d && (val_d == COIN_5C) && (t5_q != 16'hFFFF)) begin
      t5_d = t5_q + 16'd1;
    end else begin
      t5_d = t5_q;
    end
    if (in_en_d && (val_d == COIN_10C) && (t10_q != 16'hFFFF)) begin
      t10_d = t10_q + 16'd1;
    end else begin
      t10_d = t10_q;
    end
    if ((rej_d || jam_enter_s) && (trej_q != 16'hFFFF)) begin
      trej_d = trej_q + 16'd1;
    end else begin
      trej_d = trej_q;
    end
  end

  // Tally registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t5_q   <= 16'd0;
      t10_q  <= 16'd0;
      trej_q <= 16'd0;
    end else begin
      t5_q   <= t5_d;
      t10_q  <= t10_d;
      trej_q <= trej_d;
    end
  end

  assign bus.tally_5c  = t5_q;
  assign bus.tally_10c = t10_q;
  assign bus.tally_rej = trej_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
//   Directed bench for coin_acceptor (default build). A vector table of sensor
//   pulses with hand-computed strobe counts is applied in a loop, followed by
//   hand-written jam and reset-mid-pulse sequences.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  coin_acceptor_if bus ();

  coin_acceptor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Strobe monitor, sampled on the falling edge away from the active edge.
  int n_acc     = 0;
  int n_val1    = 0;
  int n_rej     = 0;
  int n_overlap = 0;
  int n_valbad  = 0;

  // Counts strobes and illegal output combinations.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.coin_in_en) begin
        n_acc <= n_acc + 1;
        if (bus.coin_val) n_val1 <= n_val1 + 1;
      end
      if (bus.coin_reject) n_rej <= n_rej + 1;
      if (bus.coin_in_en && bus.coin_reject) n_overlap <= n_overlap + 1;
      if (!bus.coin_in_en && bus.coin_val) n_valbad <= n_valbad + 1;
    end
  end

  typedef struct {
    string name;
    int    width;
    bit    acc_start;
    bit    acc_mid;
    bit    glitch;
    int    exp_acc;
    int    exp_val1;
    int    exp_rej;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one coin; with glitch set, adds 3-cycle glitches on both edges and
  // a 5-cycle dropout in the middle (debounced width about 256).
  task automatic drive_pulse(input int width, input bit acc0, input bit acc1,
                             input bit glitch);
    @(negedge clk);
    bus.accept_en = acc0;
    if (!glitch) begin
      bus.coin_sense = 1'b1;
      cycles(width / 2);
      bus.accept_en = acc1;
      cycles(width - width / 2);
      bus.coin_sense = 1'b0;
    end else begin
      bus.coin_sense = 1'b1; cycles(3);
      bus.coin_sense = 1'b0; cycles(3);
      bus.coin_sense = 1'b1; cycles(120);
      bus.accept_en = acc1;
      bus.coin_sense = 1'b0; cycles(5);
      bus.coin_sense = 1'b1; cycles(125);
      bus.coin_sense = 1'b0; cycles(3);
      bus.coin_sense = 1'b1; cycles(3);
      bus.coin_sense = 1'b0;
    end
    cycles(60);
  endtask

  int a0, v0, r0;

  initial begin
    vecs[0] = '{"clean_250",    250, 1'b1, 1'b1, 1'b0, 1, 0, 0};
    vecs[1] = '{"clean_900",    900, 1'b1, 1'b1, 1'b0, 1, 1, 0};
    vecs[2] = '{"gap_500",      500, 1'b1, 1'b1, 1'b0, 0, 0, 1};
    vecs[3] = '{"short_50",      50, 1'b1, 1'b1, 1'b0, 0, 0, 1};
    vecs[4] = '{"glitchy_250",  250, 1'b1, 1'b1, 1'b1, 1, 0, 0};
    vecs[5] = '{"locked_900",   900, 1'b0, 1'b1, 1'b0, 0, 0, 1};
    vecs[6] = '{"unlock_mid",   250, 1'b1, 1'b0, 1'b0, 1, 0, 0};
    vecs[7] = '{"long_1300",   1300, 1'b1, 1'b1, 1'b0, 0, 0, 1};

    // Reset state.
    reset          = 1'b1;
    bus.coin_sense = 1'b0;
    bus.accept_en  = 1'b0;
    cycles(4);
    chk("rst_coin_in_en",  int'(bus.coin_in_en), 0);
    chk("rst_coin_val",    int'(bus.coin_val), 0);
    chk("rst_coin_reject", int'(bus.coin_reject), 0);
    chk("rst_jam",         int'(bus.jam), 0);
    chk("rst_busy",        int'(bus.busy), 0);
    reset = 1'b0;
    cycles(8);
    chk("idle_busy", int'(bus.busy), 0);

    // Table-driven coins.
    for (int i = 0; i < 8; i++) begin
      a0 = n_acc; v0 = n_val1; r0 = n_rej;
      drive_pulse(vecs[i].width, vecs[i].acc_start, vecs[i].acc_mid, vecs[i].glitch);
      chk({vecs[i].name, "_accepts"}, n_acc - a0, vecs[i].exp_acc);
      chk({vecs[i].name, "_val10"},   n_val1 - v0, vecs[i].exp_val1);
      chk({vecs[i].name, "_rejects"}, n_rej - r0, vecs[i].exp_rej);
      chk({vecs[i].name, "_jam"},     int'(bus.jam), 0);
      chk({vecs[i].name, "_busy"},    int'(bus.busy), 0);
    end

    // Jam: sensor held high 5000 cycles.
    a0 = n_acc; r0 = n_rej;
    @(negedge clk);
    bus.accept_en  = 1'b1;
    bus.coin_sense = 1'b1;
    cycles(200);
    chk("measure_busy", int'(bus.busy), 1);
    cycles(3790);
    chk("jam_before_4000", int'(bus.jam), 0);
    cycles(60);
    chk("jam_after_4000", int'(bus.jam), 1);
    cycles(950);
    chk("jam_held", int'(bus.jam), 1);
    bus.coin_sense = 1'b0;
    cycles(60);
    chk("jam_cleared", int'(bus.jam), 0);
    chk("jam_no_accept", n_acc - a0, 0);
    chk("jam_no_reject", n_rej - r0, 0);
    a0 = n_acc; v0 = n_val1;
    drive_pulse(250, 1'b1, 1'b1, 1'b0);
    chk("post_jam_accept", n_acc - a0, 1);
    chk("post_jam_val10",  n_val1 - v0, 0);

    // Reset mid-pulse, released with the coin still in the beam.
    a0 = n_acc; r0 = n_rej;
    @(negedge clk);
    bus.coin_sense = 1'b1;
    cycles(300);
    reset = 1'b1;
    cycles(3);
    chk("midrst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    cycles(400);
    chk("rearm_wait_busy", int'(bus.busy), 1);
    bus.coin_sense = 1'b0;
    cycles(60);
    chk("rearm_idle_busy", int'(bus.busy), 0);
    chk("midrst_no_accept", n_acc - a0, 0);
    chk("midrst_no_reject", n_rej - r0, 0);
    a0 = n_acc;
    drive_pulse(250, 1'b1, 1'b1, 1'b0);
    chk("post_rst_accept", n_acc - a0, 1);

    // Global invariants over the whole run.
    chk("strobe_overlap", n_overlap, 0);
    chk("val_without_en", n_valbad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
